// File: rtl/nios2_ls_sysid_pkg.sv
// Shared types and constants for the system-ID checker (Avalon-MM read master).
package nios2_ls_sysid_pkg;

   typedef enum logic [2:0] {
      IDLE,
      RD_ID,
      WT_ID,
      RD_TS,
      WT_TS,
      FIN
   } sysid_state_e;

   localparam logic        SYSID_ADDR_ID    = 1'b0;
   localparam logic        SYSID_ADDR_TS    = 1'b1;
   localparam logic [31:0] SYSID_DEFAULT_ID = 32'h0000_0000;
   localparam logic [31:0] SYSID_DEFAULT_TS = 32'h5BA8_8A10;

   // True while a read is in flight (command phase or waiting for data).
   function automatic logic sysid_in_read(input sysid_state_e s);
      return (s inside {RD_ID, WT_ID, RD_TS, WT_TS});
   endfunction

endpackage

// File: rtl/nios2_ls_sysid_timeout_ctr.sv
// Per-read wait counter: load clears it, enable counts up, expire flags the limit.
module nios2_ls_sysid_timeout_ctr #(
   parameter int LIMIT = 255
) (
   input  logic clock,
   input  logic reset,
   input  logic load_i,
   input  logic en_i,
   output logic expire_o
);

   localparam int            W       = $clog2(LIMIT + 1);
   localparam logic [W-1:0]  LIMIT_W = W'(LIMIT);

   logic [W-1:0] cnt_q;
   logic [W-1:0] cnt_d;

   always_comb begin
      // NOTE: default assignment first so the combinational block never infers a latch.
      cnt_d = cnt_q;
      if (load_i) begin
         cnt_d = '0;
      end else if (en_i && !expire_o) begin
         cnt_d = cnt_q + W'(1);
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign expire_o = (cnt_q == LIMIT_W);

endmodule

// File: rtl/nios2_ls_sysid_checker.sv
// Reads system ID and build timestamp over Avalon-MM and compares them to baked-in values.
// Optional per-read timeout: define SYSID_TIMEOUT_EN.
module nios2_ls_sysid_checker
   import nios2_ls_sysid_pkg::*;
#(
   parameter logic [31:0] EXPECTED_ID    = SYSID_DEFAULT_ID,
   parameter logic [31:0] EXPECTED_TS    = SYSID_DEFAULT_TS,
   parameter int          TIMEOUT_CYCLES = 255
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        start,
   output logic        avm_address,
   output logic        avm_read,
   input  logic        avm_waitrequest,
   input  logic        avm_readdatavalid,
   input  logic [31:0] avm_readdata,
   output logic        busy,
   output logic        done,
   output logic [31:0] id_value,
   output logic [31:0] ts_value,
   output logic        id_ok,
   output logic        ts_ok,
   output logic        timeout
);

   sysid_state_e state_q;
   logic         avm_read_q;
   logic         avm_address_q;
   logic         busy_q;
   logic         done_q;
   logic [31:0]  id_value_q;
   logic [31:0]  ts_value_q;
   logic         id_ok_q;
   logic         ts_ok_q;
   logic         expire;

`ifdef SYSID_TIMEOUT_EN
   logic tmo_load;
   logic tmo_en;
   logic id_to_ts;
   logic timeout_q;

   // The counter restarts whenever the FSM moves on to the timestamp read.
   assign id_to_ts = ((state_q == RD_ID) && !avm_waitrequest && avm_readdatavalid) ||
                     ((state_q == WT_ID) && avm_readdatavalid);
   assign tmo_en   = sysid_in_read(state_q);
   assign tmo_load = !tmo_en || id_to_ts;

   nios2_ls_sysid_timeout_ctr #(
      .LIMIT (TIMEOUT_CYCLES)
   ) u_timeout_ctr (
      .clock    (clock),
      .reset    (reset),
      .load_i   (tmo_load),
      .en_i     (tmo_en),
      .expire_o (expire)
   );

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         timeout_q <= 1'b0;
      end else if ((state_q == IDLE) && start) begin
         timeout_q <= 1'b0;
      end else if (expire && tmo_en) begin
         timeout_q <= 1'b1;
      end
   end

   assign timeout = timeout_q;
`else
   logic [31:0] unused_timeout_cfg;

   assign unused_timeout_cfg = TIMEOUT_CYCLES;
   assign expire             = 1'b0;
   assign timeout            = 1'b0;
`endif

   always_ff @(posedge clock or posedge reset) begin
      // NOTE: async reset clears every register, so avm_read drops the instant reset rises.
      if (reset) begin
         state_q       <= IDLE;
         avm_read_q    <= 1'b0;
         avm_address_q <= SYSID_ADDR_ID;
         busy_q        <= 1'b0;
         done_q        <= 1'b0;
         id_value_q    <= '0;
         ts_value_q    <= '0;
         id_ok_q       <= 1'b0;
         ts_ok_q       <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments only, so all branches see pre-edge state.
         done_q <= 1'b0;
         if (expire && sysid_in_read(state_q)) begin
            state_q    <= FIN;
            avm_read_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b1;
            id_ok_q    <= 1'b0;
            ts_ok_q    <= 1'b0;
         end else begin
            case (state_q)
               IDLE: begin
                  if (start) begin
                     state_q       <= RD_ID;
                     avm_read_q    <= 1'b1;
                     avm_address_q <= SYSID_ADDR_ID;
                     busy_q        <= 1'b1;
                     id_value_q    <= '0;
                     ts_value_q    <= '0;
                     id_ok_q       <= 1'b0;
                     ts_ok_q       <= 1'b0;
                  end
               end
               RD_ID: begin
                  if (!avm_waitrequest) begin
                     avm_read_q <= 1'b0;
                     state_q    <= WT_ID;
                     // Zero-latency slave: data arrives with the accept.
                     if (avm_readdatavalid) begin
                        id_value_q    <= avm_readdata;
                        state_q       <= RD_TS;
                        avm_read_q    <= 1'b1;
                        avm_address_q <= SYSID_ADDR_TS;
                     end
                  end
               end
               WT_ID: begin
                  if (avm_readdatavalid) begin
                     id_value_q    <= avm_readdata;
                     state_q       <= RD_TS;
                     avm_read_q    <= 1'b1;
                     avm_address_q <= SYSID_ADDR_TS;
                  end
               end
               RD_TS: begin
                  if (!avm_waitrequest) begin
                     avm_read_q <= 1'b0;
                     state_q    <= WT_TS;
                     if (avm_readdatavalid) begin
                        ts_value_q <= avm_readdata;
                        state_q    <= FIN;
                        busy_q     <= 1'b0;
                        done_q     <= 1'b1;
                        id_ok_q    <= (id_value_q == EXPECTED_ID);
                        ts_ok_q    <= (avm_readdata == EXPECTED_TS);
                     end
                  end
               end
               WT_TS: begin
                  if (avm_readdatavalid) begin
                     ts_value_q <= avm_readdata;
                     state_q    <= FIN;
                     busy_q     <= 1'b0;
                     done_q     <= 1'b1;
                     id_ok_q    <= (id_value_q == EXPECTED_ID);
                     ts_ok_q    <= (avm_readdata == EXPECTED_TS);
                  end
               end
               FIN: begin
                  state_q <= IDLE;
               end
               default: begin
                  state_q    <= IDLE;
                  avm_read_q <= 1'b0;
                  busy_q     <= 1'b0;
               end
            endcase
         end
      end
   end

   assign avm_read    = avm_read_q;
   assign avm_address = avm_address_q;
   assign busy        = busy_q;
   assign done        = done_q;
   assign id_value    = id_value_q;
   assign ts_value    = ts_value_q;
   assign id_ok       = id_ok_q;
   assign ts_ok       = ts_ok_q;

endmodule

// File: tb/tb_nios2_ls_sysid_checker.sv
// Self-checking bench: behavioural Avalon slave plus a cycle-count/compare reference model.
module tb_nios2_ls_sysid_checker;

   localparam logic [31:0] EXP_ID = 32'h0000_0000;
   localparam logic [31:0] EXP_TS = 32'h5BA8_8A10;

   logic        clock;
   logic        reset;
   logic        start;
   logic        avm_address;
   logic        avm_read;
   logic        avm_waitrequest;
   logic        avm_readdatavalid;
   logic [31:0] avm_readdata;
   logic        busy;
   logic        done;
   logic [31:0] id_value;
   logic [31:0] ts_value;
   logic        id_ok;
   logic        ts_ok;
   logic        timeout;

   int n_checks = 0;
   int n_errors = 0;

   // Slave configuration (written by the main process only)
   logic [31:0] cfg_id, cfg_ts;
   int          cfg_w0, cfg_w1, cfg_l0, cfg_l1;
   int          reads_base;
   int          spur_req;

   // Slave bookkeeping (written by the slave process only)
   int          reads_seen = 0;
   int          addr_err   = 0;
   int          spur_ack   = 0;

   nios2_ls_sysid_checker dut (
      .clock             (clock),
      .reset             (reset),
      .start             (start),
      .avm_address       (avm_address),
      .avm_read          (avm_read),
      .avm_waitrequest   (avm_waitrequest),
      .avm_readdatavalid (avm_readdatavalid),
      .avm_readdata      (avm_readdata),
      .busy              (busy),
      .done              (done),
      .id_value          (id_value),
      .ts_value          (ts_value),
      .id_ok             (id_ok),
      .ts_ok             (ts_ok),
      .timeout           (timeout)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", tag, got, exp, $time);
      end
   endtask

   // Behavioural Avalon slave: responses change on the falling edge for the next rising edge.
   initial begin
      bit          in_cmd;
      logic        cmd_addr;
      int          wait_left, lat, pend_left, idx;
      logic [31:0] pend_data, data;
      in_cmd    = 1'b0;
      cmd_addr  = 1'b0;
      wait_left = 0;
      lat       = 0;
      pend_left = 0;
      pend_data = '0;
      avm_waitrequest   = 1'b0;
      avm_readdatavalid = 1'b0;
      avm_readdata      = '0;
      forever begin
         @(negedge clock);
         avm_readdatavalid = 1'b0;
         avm_waitrequest   = 1'b0;
         if (reset) begin
            in_cmd    = 1'b0;
            pend_left = 0;
            continue;
         end
         if (pend_left > 0) begin
            pend_left--;
            if (pend_left == 0) begin
               avm_readdatavalid = 1'b1;
               avm_readdata      = pend_data;
            end
         end else if (spur_ack != spur_req) begin
            spur_ack++;
            avm_readdatavalid = 1'b1;
            avm_readdata      = 32'hDEAD_BEEF;
         end
         if (avm_read) begin
            if (!in_cmd) begin
               in_cmd   = 1'b1;
               cmd_addr = avm_address;
               idx      = reads_seen - reads_base;
               wait_left = (idx == 0) ? cfg_w0 : cfg_w1;
               lat       = (idx == 0) ? cfg_l0 : cfg_l1;
               if (idx > 1 || avm_address != (idx == 1)) addr_err++;
            end else if (avm_address != cmd_addr) begin
               addr_err++;
            end
            if (wait_left > 0) begin
               avm_waitrequest = 1'b1;
               wait_left--;
            end else begin
               in_cmd = 1'b0;
               reads_seen++;
               data = cmd_addr ? cfg_ts : cfg_id;
               if (lat == 0) begin
                  avm_readdatavalid = 1'b1;
                  avm_readdata      = data;
               end else begin
                  pend_left = lat;
                  pend_data = data;
               end
            end
         end
      end
   end

   task automatic do_reset();
      reset = 1'b1;
      @(posedge clock);
      @(posedge clock);
      #1 reset = 1'b0;
      @(posedge clock);
      #1;
   endtask

   task automatic check_reset_values();
      check("rst_read",    avm_read,    1'b0);
      check("rst_addr",    avm_address, 1'b0);
      check("rst_busy",    busy,        1'b0);
      check("rst_done",    done,        1'b0);
      check("rst_id_val",  id_value,    32'h0);
      check("rst_ts_val",  ts_value,    32'h0);
      check("rst_id_ok",   id_ok,       1'b0);
      check("rst_ts_ok",   ts_ok,       1'b0);
      check("rst_timeout", timeout,     1'b0);
   endtask

   // Begin a check: raise start for one rising edge (called #1 after an edge, DUT idle).
   task automatic pulse_start();
      start = 1'b1;
      @(posedge clock);
      #1 start = 1'b0;
   endtask

   // One full check; the model predicts latency as the sum over both reads of
   // (wait cycles + 1 accept cycle + read latency), counted in edges after start.
   task automatic run_check(input logic [31:0] id_w, input logic [31:0] ts_w,
                            input int w0, input int l0, input int w1, input int l1,
                            input bit repulse);
      int  exp_edges, edges, extra_done, base_err;
      bit  seen, pulsed;
      cfg_id = id_w;  cfg_ts = ts_w;
      cfg_w0 = w0;    cfg_l0 = l0;
      cfg_w1 = w1;    cfg_l1 = l1;
      reads_base = reads_seen;
      base_err   = addr_err;
      exp_edges  = (w0 + 1 + l0) + (w1 + 1 + l1);
      pulse_start();
      check("busy_after_start", busy, 1'b1);
      check("id_val_cleared", id_value, (w0 == 0 && l0 == 0) ? id_value : 32'h0);
      seen   = 1'b0;
      pulsed = 1'b0;
      edges  = 0;
      for (int c = 1; c <= 64; c++) begin
         if (repulse && !pulsed && avm_read && avm_address) begin
            start  = 1'b1;
            pulsed = 1'b1;
         end
         @(posedge clock);
         #1 start = 1'b0;
         if (done) begin
            seen  = 1'b1;
            edges = c;
            break;
         end
      end
      check("done_seen", seen, 1'b1);
      check("latency", edges, exp_edges);
      check("id_value", id_value, id_w);
      check("ts_value", ts_value, ts_w);
      check("id_ok", id_ok, id_w == EXP_ID);
      check("ts_ok", ts_ok, ts_w == EXP_TS);
      check("timeout_clear", timeout, 1'b0);
      check("reads_on_bus", reads_seen - reads_base, 2);
      check("addr_stable", addr_err - base_err, 0);
      extra_done = 0;
      for (int c = 0; c < (repulse ? 6 : 1); c++) begin
         @(posedge clock);
         #1;
         if (done) extra_done++;
      end
      check("done_one_pulse", extra_done, 0);
      check("busy_idle", busy, 1'b0);
      check("id_ok_hold", id_ok, id_w == EXP_ID);
      if (repulse) check("repulse_reads", reads_seen - reads_base, 2);
   endtask

   initial begin
      logic [31:0] id_w, ts_w;
      reset = 1'b1;
      start = 1'b0;
      cfg_id = EXP_ID; cfg_ts = EXP_TS;
      cfg_w0 = 0; cfg_w1 = 0; cfg_l0 = 1; cfg_l1 = 1;
      reads_base = 0;
      spur_req   = 0;
      do_reset();
      check_reset_values();

      // Directed cases
      run_check(EXP_ID, EXP_TS, 0, 1, 0, 1, 1'b0);
      run_check(EXP_ID, 32'h5BA8_8A11, 0, 1, 0, 1, 1'b0);
      run_check(EXP_ID, EXP_TS, 3, 1, 3, 1, 1'b0);
      run_check(32'h0000_0001, EXP_TS, 3, 1, 3, 1, 1'b1);
      run_check(EXP_ID, EXP_TS, 0, 0, 0, 0, 1'b0);

      // Stray readdatavalid while idle must be ignored
      spur_req++;
      repeat (3) @(posedge clock);
      #1;
      check("spur_id_hold", id_value, EXP_ID);
      check("spur_no_done", done, 1'b0);
      check("spur_no_busy", busy, 1'b0);

      // Reset while the ID command is stalled: avm_read drops before the next edge
      cfg_w0 = 5; cfg_l0 = 1;
      reads_base = reads_seen;
      pulse_start();
      check("rdid_read_high", avm_read, 1'b1);
      #2 reset = 1'b1;
      #1;
      check("rdid_rst_read", avm_read, 1'b0);
      check("rdid_rst_busy", busy, 1'b0);
      do_reset();

      // Reset while waiting for ID data
      cfg_w0 = 0; cfg_l0 = 2;
      reads_base = reads_seen;
      pulse_start();
      @(posedge clock);
      #1;
      check("wtid_read_low", avm_read, 1'b0);
      check("wtid_busy", busy, 1'b1);
      #2 reset = 1'b1;
      #1;
      check("wtid_rst_read", avm_read, 1'b0);
      check("wtid_rst_busy", busy, 1'b0);
      do_reset();
      check_reset_values();
      run_check(EXP_ID, EXP_TS, 0, 1, 0, 1, 1'b0);

      // Randomized transactions
      for (int t = 0; t < 16; t++) begin
         id_w = ($urandom_range(0, 1) == 1) ? EXP_ID : $urandom;
         ts_w = ($urandom_range(0, 1) == 1) ? EXP_TS : (EXP_TS ^ (32'h1 << $urandom_range(0, 31)));
         run_check(id_w, ts_w,
                   $urandom_range(0, 3), $urandom_range(0, 2),
                   $urandom_range(0, 3), $urandom_range(0, 2),
                   $urandom_range(0, 3) == 0);
      end

`ifdef SYSID_TIMEOUT_EN
      // Slave never releases waitrequest: the ID read times out
      begin
         bit seen;
         int edges;
         cfg_w0 = 100000; cfg_l0 = 1;
         reads_base = reads_seen;
         pulse_start();
         seen  = 1'b0;
         edges = 0;
         for (int c = 1; c <= 400; c++) begin
            @(posedge clock);
            #1;
            if (done) begin
               seen  = 1'b1;
               edges = c;
               break;
            end
         end
         check("tmo_done_seen", seen, 1'b1);
         check("tmo_latency", edges, 256);
         check("tmo_flag", timeout, 1'b1);
         check("tmo_id_ok", id_ok, 1'b0);
         check("tmo_ts_ok", ts_ok, 1'b0);
         check("tmo_read_low", avm_read, 1'b0);
         @(posedge clock);
         #1;
         check("tmo_sticky", timeout, 1'b1);
         do_reset();
      end
`endif

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
